// File: rtl/addr_gen_unit.sv
// LC-3 address-generation unit: base select + sign-extended IR offset, registered,
// with an optional burst of consecutive addresses behind a valid/ready handshake.
module addr_gen_unit #(
  parameter int WIDTH     = 16,
  parameter int NUM_BASE  = 2,
  parameter int MAX_BURST = 8,
  localparam int BSEL_W   = (NUM_BASE > 1) ? $clog2(NUM_BASE) : 1,
  localparam int LEN_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [BSEL_W-1:0]         base_sel,
  input  logic [NUM_BASE*WIDTH-1:0] base_in,
  input  logic [1:0]                off_sel,
  input  logic [WIDTH-1:0]          ir_in,
  input  logic [LEN_W-1:0]          burst_len,
  output logic                      addr_valid,
  input  logic                      addr_ready,
  output logic [WIDTH-1:0]          addr_out,
  output logic                      addr_last,
  output logic                      busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state_r;
  logic [LEN_W-1:0]  remain_r;
  logic [WIDTH-1:0]  base_s;
  logic [WIDTH-1:0]  offset_s;
  logic [WIDTH-1:0]  start_s;
  logic [LEN_W-1:0]  eff_len_s;
  logic              unused_s;

  function automatic logic [WIDTH-1:0] sext_offset(input logic [1:0] sel,
                                                   input logic [WIDTH-1:0] ir);
    logic [WIDTH-1:0] r;
    case (sel)
      2'd0:    r = '0;
      2'd1:    r = {{(WIDTH-6){ir[5]}},   ir[5:0]};
      2'd2:    r = {{(WIDTH-9){ir[8]}},   ir[8:0]};
      2'd3:    r = {{(WIDTH-11){ir[10]}}, ir[10:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign unused_s = ^ir_in[WIDTH-1:11];

  // Base mux; an index with no matching source yields a zero base.
  always_comb begin
    base_s = '0;
    for (int k = 0; k < NUM_BASE; k++) begin
      if (base_sel == BSEL_W'(k)) begin
        base_s = base_in[k*WIDTH +: WIDTH];
      end else begin
        base_s = base_s;
      end
    end
  end

  // Effective beat count: 0 means one beat, oversize requests clamp to MAX_BURST.
  always_comb begin
    if (burst_len == '0) begin
      eff_len_s = LEN_W'(1);
    end else if (burst_len > LEN_W'(MAX_BURST)) begin
      eff_len_s = LEN_W'(MAX_BURST);
    end else begin
      eff_len_s = burst_len;
    end
  end

  assign offset_s = sext_offset(off_sel, ir_in);
  assign start_s  = base_s + offset_s;

  // Request/beat FSM; remain_r counts beats still to follow the one on addr_out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      req_ready  <= 1'b1;
      addr_valid <= 1'b0;
      addr_out   <= '0;
      addr_last  <= 1'b0;
      busy       <= 1'b0;
      remain_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            state_r    <= ISSUE;
            req_ready  <= 1'b0;
            addr_valid <= 1'b1;
            busy       <= 1'b1;
            addr_out   <= start_s;
            remain_r   <= eff_len_s - LEN_W'(1);
            addr_last  <= (eff_len_s == LEN_W'(1));
          end
        end
        ISSUE: begin
          if (addr_valid && addr_ready) begin
            if (addr_last) begin
              state_r    <= IDLE;
              req_ready  <= 1'b1;
              addr_valid <= 1'b0;
              addr_last  <= 1'b0;
              busy       <= 1'b0;
            end else begin
              addr_out  <= addr_out + WIDTH'(1);
              remain_r  <= remain_r - LEN_W'(1);
              addr_last <= (remain_r == LEN_W'(1));
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          addr_valid <= 1'b0;
          addr_last  <= 1'b0;
          busy       <= 1'b0;
          remain_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_gen_unit.sv
// Scoreboard bench for addr_gen_unit: requests push expected beats, a monitor pops them.
module tb_addr_gen_unit;
  localparam int W  = 16;
  localparam int NB = 3;
  localparam int MB = 8;
  localparam int BW = 2;
  localparam int LW = 4;

  typedef struct {
    logic [W-1:0] a;
    logic         l;
  } beat_t;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [BW-1:0]   base_sel = '0;
  logic [NB*W-1:0] base_in = '0;
  logic [1:0]      off_sel = '0;
  logic [W-1:0]    ir_in = '0;
  logic [LW-1:0]   burst_len = '0;
  logic            addr_valid;
  logic            addr_ready = 1'b1;
  logic [W-1:0]    addr_out;
  logic            addr_last;
  logic            busy;

  beat_t        exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  bit           manual = 1'b1;
  bit           held_valid = 1'b0;
  logic [W-1:0] held_a;
  logic         held_l;

  addr_gen_unit #(.WIDTH(W), .NUM_BASE(NB), .MAX_BURST(MB)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .base_sel(base_sel), .base_in(base_in), .off_sel(off_sel), .ir_in(ir_in),
    .burst_len(burst_len), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_out(addr_out), .addr_last(addr_last), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: start address from plain integer arithmetic on the request fields.
  function automatic logic [W-1:0] ref_start(input int sel, input int osel,
                                             input logic [W-1:0] ir, input logic [NB*W-1:0] bases);
    int b;
    int off;
    b = (sel < NB) ? int'(bases[sel*W +: W]) : 0;
    case (osel)
      1:       off = int'($signed(ir[5:0]));
      2:       off = int'($signed(ir[8:0]));
      3:       off = int'($signed(ir[10:0]));
      default: off = 0;
    endcase
    return W'(b + off);
  endfunction

  task automatic push_model(input int sel, input int osel, input logic [W-1:0] ir,
                            input int len, input logic [NB*W-1:0] bases);
    int n;
    logic [W-1:0] s;
    beat_t e;
    n = (len == 0) ? 1 : ((len > MB) ? MB : len);
    s = ref_start(sel, osel, ir, bases);
    for (int i = 0; i < n; i++) begin
      e.a = W'(int'(s) + i);
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input int sel, input int osel, input logic [W-1:0] ir,
                       input int len, input bit hold);
    int cyc;
    logic [W-1:0] s;
    cyc = 0;
    while (!req_ready && cyc < 300) begin
      @(posedge Clk); #1; cyc++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    base_sel  = BW'(sel);
    off_sel   = 2'(osel);
    ir_in     = ir;
    burst_len = LW'(len);
    req_valid = 1'b1;
    s = ref_start(sel, osel, ir, base_in);
    push_model(sel, osel, ir, len, base_in);
    @(posedge Clk); #1;
    check("accept_valid", {31'd0, addr_valid}, 32'd1);
    check("accept_addr", {16'd0, addr_out}, {16'd0, s});
    check("accept_busy", {31'd0, busy}, 32'd1);
    if (hold) begin
      cyc = 0;
      while (busy && cyc < 100) begin
        check("req_ready_issue", {31'd0, req_ready}, 32'd0);
        ir_in     = 16'($urandom);
        base_in   = {16'($urandom), 16'($urandom), 16'($urandom)};
        base_sel  = 2'($urandom);
        burst_len = 4'($urandom);
        @(posedge Clk); #1; cyc++;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((busy || exp_q.size() != 0) && cyc < 400) begin
      @(posedge Clk); #1; cyc++;
    end
    check("idle_reached", {31'd0, (cyc < 400)}, 32'd1);
  endtask

  // Random consumer backpressure when not under directed control.
  always @(posedge Clk) begin
    #1;
    if (!manual) addr_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops on accepted beats, checks stalled beats stay put.
  always @(negedge Clk) begin
    if (!Reset && addr_valid) begin
      if (held_valid) begin
        check("hold_addr", {16'd0, addr_out}, {16'd0, held_a});
        check("hold_last", {31'd0, addr_last}, {31'd0, held_l});
      end
      if (addr_ready) begin
        held_valid = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got addr %h with no beat expected", addr_out);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_addr", {16'd0, addr_out}, {16'd0, e.a});
          check("beat_last", {31'd0, addr_last}, {31'd0, e.l});
        end
      end else begin
        held_valid = 1'b1;
        held_a = addr_out;
        held_l = addr_last;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  initial begin
    #2;
    check("rst_valid", {31'd0, addr_valid}, 32'd0);
    check("rst_addr", {16'd0, addr_out}, 32'd0);
    check("rst_last", {31'd0, addr_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Single beat from PC with a negative offset9
    base_in[15:0] = 16'h3000;
    issue(0, 2, 16'h01FE, 1, 1'b0);
    wait_idle();
    check("single_addr_hold", {16'd0, addr_out}, 32'h2FFE);
    check("single_last_clr", {31'd0, addr_last}, 32'd0);

    // SR1 base with offset6
    base_in[31:16] = 16'h4000;
    issue(1, 1, 16'h001F, 1, 1'b0);
    wait_idle();

    // Four-beat burst wrapping through zero, beat 2 stalled three cycles
    base_in[15:0] = 16'hFFFE;
    issue(0, 0, 16'h0000, 4, 1'b0);
    @(posedge Clk); #1;
    addr_ready = 1'b0;
    repeat (3) begin
      check("stall_addr", {16'd0, addr_out}, 32'hFFFF);
      check("stall_valid", {31'd0, addr_valid}, 32'd1);
      @(posedge Clk); #1;
    end
    addr_ready = 1'b1;
    wait_idle();

    // Length boundaries
    issue(0, 1, 16'h0020, 0, 1'b0);
    wait_idle();
    issue(1, 3, 16'h03FF, 15, 1'b0);
    wait_idle();
    check("queue_drained", exp_q.size(), 32'd0);

    // Reset during beat 2 of 4
    base_in[31:16] = 16'h1230;
    issue(1, 0, 16'h0000, 4, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    check("midrst_valid", {31'd0, addr_valid}, 32'd0);
    check("midrst_addr", {16'd0, addr_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) begin
      @(posedge Clk); #1;
      check("midrst_no_beat", {31'd0, addr_valid}, 32'd0);
    end

    // req_valid held through ISSUE with changing inputs, then out-of-range select
    base_in = {16'h7777, 16'h5000, 16'h6000};
    issue(1, 2, 16'h0003, 3, 1'b1);
    wait_idle();
    issue(3, 3, 16'h0400, 2, 1'b0);
    wait_idle();

    // Randomized requests under random backpressure
    manual = 1'b0;
    for (int i = 0; i < 40; i++) begin
      base_in = {16'($urandom), 16'($urandom), 16'($urandom)};
      if ($urandom_range(0, 7) == 0) base_in[15:0] = 16'hFFFD;
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom),
            int'($urandom_range(0, 15)), bit'($urandom_range(0, 3) == 0));
    end
    manual = 1'b1;
    addr_ready = 1'b1;
    wait_idle();
    check("final_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
